// File: rtl/instr_decode_stage_pkg.sv
// Shared decode definitions: type encodings, field offsets, reserved opcodes.
// Latency: none (definitions only).
// Backpressure: not applicable.
package mini_risc_decode_pkg;

    typedef enum logic [1:0] {
        TYPE_R   = 2'b00,
        TYPE_I   = 2'b01,
        TYPE_J   = 2'b10,
        TYPE_RSV = 2'b11
    } instr_type_t;

    localparam int OPC_W = 6;
    localparam int REG_W = 5;

    // Field offsets measured downward from the instruction MSB, so wider
    // instruction words keep the same layout at the top.
    localparam int OPC_OFS   = 0;
    localparam int RS_OFS    = 6;
    localparam int RT_OFS    = 11;
    localparam int RD_OFS    = 16;
    localparam int SHAMT_OFS = 21;
    localparam int IMM16_OFS = 16;
    localparam int IMM26_OFS = 6;

    // opcode[5:4] pattern that marks a jump
    localparam logic [1:0] J_PREFIX = 2'b11;

    // opcode bit selecting zero-extension for the logical I-type group
    localparam int LOGIC_BIT = 3;

    // Reserved opcodes, flagged only when the illegal check is built in
    localparam int N_RSV = 4;
    localparam logic [N_RSV*OPC_W-1:0] RSV_OPCODES = {6'h14, 6'h15, 6'h1E, 6'h1F};

    function automatic logic is_reserved_opc(input logic [OPC_W-1:0] opc);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_RSV; i++) begin
            if (RSV_OPCODES[i*OPC_W +: OPC_W] == opc) hit = 1'b1;
        end
        return hit;
    endfunction

    // Fixed-width part of a decoded instruction
    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        instr_type_t      ty;
        logic             illegal;
    } dec_fields_t;

endpackage

// File: rtl/instr_decode_stage_if.sv
// Fetch-side and register-read-side handshake bundle of the decode stage.
// Latency: none (wiring only).
// Backpressure: valid/ready on both sides; slave is the stage, master the neighbours.
interface instr_decode_stage_if #(
    parameter int INSTR_W = 32,
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int FUNCT_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [5:0]         out_opcode;
    logic [4:0]         out_rs;
    logic [4:0]         out_rt;
    logic [4:0]         out_rd;
    logic [FUNCT_W-1:0] out_funct;
    logic [DATA_W-1:0]  out_imm;
    logic [1:0]         out_type;
    logic               out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt,
               out_rd, out_funct, out_imm, out_type, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt,
               out_rd, out_funct, out_imm, out_type, out_illegal
    );
endinterface

// File: rtl/instr_decode_stage_decode_comb.sv
// Field split, R/I/J classification and immediate extension of one instruction.
// Latency: purely combinational.
// Backpressure: none; optional illegal check under DECODE_ILLEGAL_CHECK_EN.
module decode_comb
    import mini_risc_decode_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int DATA_W  = 32,
    parameter int FUNCT_W = 4
) (
    input  logic [INSTR_W-1:0] instr_i,
    output dec_fields_t        fields_o,
    output logic [FUNCT_W-1:0] funct_o,
    output logic [DATA_W-1:0]  imm_o
);

    logic [OPC_W-1:0] opc;
    logic [15:0]      imm16;
    logic [25:0]      imm26;
    instr_type_t      base_ty;
    logic             illegal;

    assign opc   = instr_i[INSTR_W-1-OPC_OFS -: OPC_W];
    assign imm16 = instr_i[INSTR_W-1-IMM16_OFS -: 16];
    assign imm26 = instr_i[INSTR_W-1-IMM26_OFS -: 26];

    // Classify from the opcode alone; reserved opcodes fall into I-type here
    always_comb begin
        base_ty = TYPE_I;
        if (opc == '0) begin
            base_ty = TYPE_R;
        end else if (opc[OPC_W-1 -: 2] == J_PREFIX) begin
            base_ty = TYPE_J;
        end
    end

`ifdef DECODE_ILLEGAL_CHECK_EN
    assign illegal = is_reserved_opc(opc) ||
                     ((base_ty == TYPE_R) && (|instr_i[INSTR_W-1-SHAMT_OFS:FUNCT_W]));
`else
    assign illegal = 1'b0;
`endif

    // Split fields; rd/funct only meaningful for R-type, immediate per class
    always_comb begin
        fields_o         = '0;
        funct_o          = '0;
        imm_o            = '0;
        fields_o.opcode  = opc;
        fields_o.rs      = instr_i[INSTR_W-1-RS_OFS -: REG_W];
        fields_o.rt      = instr_i[INSTR_W-1-RT_OFS -: REG_W];
        fields_o.ty      = illegal ? TYPE_RSV : base_ty;
        fields_o.illegal = illegal;
        case (base_ty)
            TYPE_R: begin
                fields_o.rd = instr_i[INSTR_W-1-RD_OFS -: REG_W];
                funct_o     = instr_i[FUNCT_W-1:0];
            end
            TYPE_J: begin
                imm_o = {{(DATA_W-26){imm26[25]}}, imm26};
            end
            default: begin
                if (opc[LOGIC_BIT]) begin
                    imm_o = {{(DATA_W-16){1'b0}}, imm16};
                end else begin
                    imm_o = {{(DATA_W-16){imm16[15]}}, imm16};
                end
            end
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage between fetch and register-read; DECODE_ILLEGAL_CHECK_EN adds illegal flagging.
// Latency: 1 cycle from accept to out_valid when empty; 1 instr/cycle sustained.
// Backpressure: 2-entry skid buffer, in_ready is a flop and drops only when both entries are held.
module instr_decode_stage
    import mini_risc_decode_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int FUNCT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    instr_decode_stage_if.slave   bus
);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        dec_fields_t        f;
        logic [FUNCT_W-1:0] funct;
        logic [DATA_W-1:0]  imm;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_FULL1 = 2'b01,
        S_FULL2 = 2'b10
    } skid_state_t;

    skid_state_t state_q, state_d;
    entry_t      main_q, skid_q, in_entry;
    logic        out_valid_q, in_ready_q;
    logic        load_main, load_skid, skid_to_main;
    logic        accept, take;

    decode_comb #(
        .INSTR_W (INSTR_W),
        .DATA_W  (DATA_W),
        .FUNCT_W (FUNCT_W)
    ) u_decode (
        .instr_i  (bus.in_instr),
        .fields_o (in_entry.f),
        .funct_o  (in_entry.funct),
        .imm_o    (in_entry.imm)
    );
    assign in_entry.pc = bus.in_pc;

    assign accept = bus.in_valid && in_ready_q && !flush;
    assign take   = out_valid_q && bus.out_ready;

    // Next state and register load controls; flush overrides everything
    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        load_main = 1'b1;
                        state_d   = S_FULL1;
                    end
                end
                S_FULL1: begin
                    if (take && accept) begin
                        load_main = 1'b1;
                    end else if (take) begin
                        state_d = S_EMPTY;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = S_FULL2;
                    end
                end
                S_FULL2: begin
                    if (take) begin
                        skid_to_main = 1'b1;
                        state_d      = S_FULL1;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    // State and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d != S_EMPTY);
            in_ready_q  <= (state_d != S_FULL2);
        end
    end

    // Main output register: fresh decode or promoted skid entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
        end else if (load_main) begin
            main_q <= in_entry;
        end else if (skid_to_main) begin
            main_q <= skid_q;
        end
    end

    // Skid entry catches the instruction accepted while output is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q <= '0;
        end else if (load_skid) begin
            skid_q <= in_entry;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = main_q.pc;
    assign bus.out_opcode  = main_q.f.opcode;
    assign bus.out_rs      = main_q.f.rs;
    assign bus.out_rt      = main_q.f.rt;
    assign bus.out_rd      = main_q.f.rd;
    assign bus.out_funct   = main_q.funct;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_type    = main_q.f.ty;
    assign bus.out_illegal = main_q.f.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Randomized and directed bench for instr_decode_stage against a queue model.
// Latency: checks exactly one cycle accept-to-valid.
// Backpressure: random out_ready/flush exercise both skid entries.
module tb_instr_decode_stage;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    instr_decode_stage_if #(.INSTR_W(32), .DATA_W(32), .PC_W(32), .FUNCT_W(4)) bus ();

    instr_decode_stage #(.INSTR_W(32), .DATA_W(32), .PC_W(32), .FUNCT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

`ifdef DECODE_ILLEGAL_CHECK_EN
    localparam logic       ILL_EXP  = 1'b1;
    localparam logic [1:0] ILL_TYPE = 2'b11;
`else
    localparam logic       ILL_EXP  = 1'b0;
    localparam logic [1:0] ILL_TYPE = 2'b00;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [3:0]  funct;
        logic [31:0] imm;
        logic [1:0]  ty;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Reference decode written straight from the instruction-set rules
    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.op    = 6'(instr >> 26);
        e.rs    = 5'(instr >> 21);
        e.rt    = 5'(instr >> 16);
        e.rd    = 5'd0;
        e.funct = 4'd0;
        e.imm   = 32'd0;
        e.ill   = 1'b0;
        if (e.op == 6'd0) begin
            e.ty    = 2'b00;
            e.rd    = 5'(instr >> 11);
            e.funct = 4'(instr);
        end else if (e.op >= 6'd48) begin
            e.ty  = 2'b10;
            e.imm = (instr & 32'h03FF_FFFF) | (((instr & 32'h0200_0000) != 0) ? 32'hFC00_0000 : 32'h0);
        end else begin
            e.ty = 2'b01;
            if ((e.op & 6'd8) != 0)
                e.imm = instr & 32'h0000_FFFF;
            else
                e.imm = (instr & 32'h0000_FFFF) | (((instr & 32'h0000_8000) != 0) ? 32'hFFFF_0000 : 32'h0);
        end
`ifdef DECODE_ILLEGAL_CHECK_EN
        if (e.op == 6'h14 || e.op == 6'h15 || e.op == 6'h1E || e.op == 6'h1F ||
            (e.op == 6'd0 && ((instr >> 4) & 32'h7F) != 0)) begin
            e.ill = 1'b1;
            e.ty  = 2'b11;
        end
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.in_instr  = instr;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        flush         = fl;
    endtask

    // Model: a FIFO of at most two decoded instructions
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            logic can_acc;
            can_acc = (q.size() < 2);
            if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && can_acc) q.push_back(model(bus.in_instr, bus.in_pc));
        end
    end

    // Compare DUT against the model every cycle out of reset
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("out_valid", bus.out_valid, q.size() > 0);
            chk("in_ready", bus.in_ready, q.size() < 2);
            if (q.size() > 0) begin
                chk("m_pc", bus.out_pc, q[0].pc);
                chk("m_opcode", bus.out_opcode, q[0].op);
                chk("m_rs", bus.out_rs, q[0].rs);
                chk("m_rt", bus.out_rt, q[0].rt);
                chk("m_rd", bus.out_rd, q[0].rd);
                chk("m_funct", bus.out_funct, q[0].funct);
                chk("m_imm", bus.out_imm, q[0].imm);
                chk("m_type", bus.out_type, q[0].ty);
                chk("m_illegal", bus.out_illegal, q[0].ill);
            end
        end
    end

    logic [31:0] pc_cnt;
    logic [31:0] rinstr;
    logic [5:0]  rop;

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 32'h8C22_FFF0, 32'h100, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_imm", bus.out_imm, 32'h0);
        chk("rst_out_pc", bus.out_pc, 32'h0);
        chk("rst_out_type", bus.out_type, 2'b00);

        // Release reset with the instruction already presented
        rst_n = 1'b1;
        #1 chk("pre_accept_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        chk("lat1_valid", bus.out_valid, 1'b1);
        chk("i_type", bus.out_type, 2'b01);
        chk("i_rs", bus.out_rs, 5'd1);
        chk("i_rt", bus.out_rt, 5'd2);
        chk("i_rd", bus.out_rd, 5'd0);
        chk("i_imm", bus.out_imm, 32'hFFFF_FFF0);
        chk("i_pc", bus.out_pc, 32'h100);

        drive(1'b1, 32'hE3FF_FFFF, 32'h104, 1'b1, 1'b0);
        @(negedge clk);
        chk("j_type", bus.out_type, 2'b10);
        chk("j_imm_neg", bus.out_imm, 32'hFFFF_FFFF);

        drive(1'b1, 32'hE1FF_FFFF, 32'h108, 1'b1, 1'b0);
        @(negedge clk);
        chk("j_imm_pos", bus.out_imm, 32'h01FF_FFFF);

        drive(1'b1, 32'h0022_1805, 32'h10C, 1'b1, 1'b0);
        @(negedge clk);
        chk("r_type", bus.out_type, 2'b00);
        chk("r_rd", bus.out_rd, 5'd3);
        chk("r_funct", bus.out_funct, 4'd5);
        chk("r_imm", bus.out_imm, 32'h0);

        drive(1'b1, 32'h0022_1855, 32'h110, 1'b1, 1'b0);
        @(negedge clk);
        chk("ill_flag", bus.out_illegal, ILL_EXP);
        chk("ill_type", bus.out_type, ILL_TYPE);

        // Drain, then stall downstream while streaming three instructions
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("drained", bus.out_valid, 1'b0);
        drive(1'b1, 32'h2001_0001, 32'h200, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_rdy_after1", bus.in_ready, 1'b1);
        drive(1'b1, 32'h2001_0002, 32'h204, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_rdy_after2", bus.in_ready, 1'b0);
        chk("bp_head_pc", bus.out_pc, 32'h200);
        drive(1'b1, 32'h2001_0003, 32'h208, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_third_blocked", bus.in_ready, 1'b0);
        chk("bp_head_stable", bus.out_pc, 32'h200);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("bp_second_pc", bus.out_pc, 32'h204);
        chk("bp_second_imm", bus.out_imm, 32'h0000_0002);
        chk("bp_rdy_back", bus.in_ready, 1'b1);
        @(negedge clk);
        chk("bp_empty", bus.out_valid, 1'b0);

        // Fill both entries, then flush together with a downstream take
        drive(1'b1, 32'h2001_0011, 32'h300, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h2001_0012, 32'h304, 1'b0, 1'b0);
        @(negedge clk);
        chk("fl_full2", bus.in_ready, 1'b0);
        drive(1'b1, 32'h2001_0013, 32'h308, 1'b1, 1'b1);
        @(negedge clk);
        chk("fl_valid", bus.out_valid, 1'b0);
        chk("fl_ready", bus.in_ready, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("fl_no_ghost", bus.out_valid, 1'b0);
        end

        // Randomized traffic with occasional flush and one async reset
        pc_cnt = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 7))
                0, 1:    rop = 6'd0;
                2:       rop = 6'(6'd48 + $urandom_range(0, 15));
                3:       rop = 6'(6'h14 + $urandom_range(0, 1));
                default: rop = 6'($urandom_range(1, 47));
            endcase
            rinstr = {rop, 26'($urandom)};
            drive($urandom_range(0, 9) < 7, rinstr, pc_cnt,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
            pc_cnt = pc_cnt + 32'd4;
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                #1;
                chk("arst_valid", bus.out_valid, 1'b0);
                chk("arst_ready", bus.in_ready, 1'b1);
                chk("arst_pc", bus.out_pc, 32'h0);
                @(negedge clk);
                rst_n = 1'b1;
            end
            @(negedge clk);
        end

        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("final_empty", bus.out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
